rename_table: RTL
=================

# rename_table

- Register-rename controller for the out-of-order front end.
- Holds the speculative architectural-to-physical map and drives it onto the decoder's `translation` input.
- Supplies the destination physical register (`p_reg`) for each renamed instruction from a circular free list.
- Keeps a committed map so the pipeline can roll back on flush.

## Interface
- `NUM_REG`, default `` `NUM_REG ``: physical register count. Legal values are 32 to 256. P = $clog2(NUM_REG).
- D (localparam) = NUM_REG-16: free-list depth.
- `clk` input, 1: the single clock.
- `n_rst` input, 1: reset, asynchronous, active-low.
- `alloc_req` input, 1: rename one instruction that writes `rw` this cycle.
- `alloc_arch` input, 4: architectural destination register.
- `alloc_ready` output, 1: a free physical register is available.
- `p_reg` output, P: physical register granted on an accepted allocation (the free-list head).
- `prev_preg` output, P: current speculative mapping of `alloc_arch`. The ROB stores it for freeing at commit.
- `commit_valid` input, 1: the oldest renamed instruction retires.
- `commit_arch` input, 4: its architectural destination.
- `commit_preg` input, P: the physical register it was allocated.
- `commit_prev_preg` input, P: the physical register it displaced, which is returned to the free list.
- `flush` input, 1: discard all uncommitted renames.
- `translation[16]` output, P each: speculative map, combinational from state.
- `free_count` output, $clog2(D+1): number of registers currently free.

## Operation
- State:
  - `spec_map[16]`, `comm_map[16]`.
  - `fl[D]` circular buffer.
  - Pointers `head` (next allocate), `comm_head` (oldest uncommitted allocation) and `tail` (next free slot).
  - Pointers wrap from D-1 to 0; D need not be a power of two.
- Reset:
  - `spec_map[i]` = `comm_map[i]` = i.
  - `fl[k]` = 16+k.
  - `head` = `comm_head` = `tail` = 0.
  - `free_count` = D, `alloc_ready` = 1, `p_reg` = 16.
- Free count = entries from `head` to `tail`, held as an explicit counter 0..D. `alloc_ready` = (count != 0).
- Accepted allocation (`alloc_req & alloc_ready & !flush`):
  - `spec_map[alloc_arch]` <= `fl[head]`.
  - `head` advances and count decrements.
  - `alloc_req` with `alloc_ready` = 0 is ignored, with no state change; the front end stalls.
- Commit (`commit_valid`):
  - `fl[tail]` <= `commit_prev_preg`, `tail` advances and count increments.
  - `comm_head` advances.
  - `comm_map[commit_arch]` <= `commit_preg`.
- Invariant: (`tail` - `comm_head`) mod D == 0, with the buffer logically full from `comm_head`. A commit never overflows the list.
- Flush, applied after any same-cycle commit:
  - `spec_map` <= `comm_map` including that commit's update.
  - `head` <= `comm_head`, post-commit.
  - Count <= D - (uncommitted allocations), which equals D minus the occupancy between `comm_head` and `head` after the rollback. That is, every speculatively allocated register becomes free again.
  - A same-cycle `alloc_req` is dropped.
- Allocation and commit in the same cycle: both apply. Count is unchanged; `head`, `tail` and `comm_head` each advance.
- Allocation and commit to the same architectural register in the same cycle: `spec_map` takes the allocation and `comm_map` takes the commit. The maps are independent.
- Commit with no outstanding allocation, or a commit whose `commit_preg` does not match `fl[comm_head]`, is a protocol error. Behaviour is undefined; simulation asserts.

## Timing
- `p_reg`, `prev_preg`, `alloc_ready`, `translation` and `free_count` are combinational from registered state and `alloc_arch`. There is no input-to-output path from `commit_*` or `flush` except through the feature below.
- Map updates are visible on `translation` the cycle after acceptance.
- During the accepting cycle the decoder reads pre-rename mappings. This is correct for a source equal to the destination.
- One allocation and one commit per cycle at most. Full throughput is one rename per cycle while `free_count` > 0.
- A register freed by a commit is allocatable the next cycle.
- `n_rst` assertion mid-operation immediately restores all reset values regardless of in-flight commits.

## Configuration
- `RENAME_FREE_BYPASS_EN` defined: when `free_count` == 0 and `commit_valid` is high, `alloc_ready` = 1 and `p_reg` = `commit_prev_preg`.
  - The allocation consumes the freed register directly.
  - `head` and `tail` both advance, and count stays 0.
  - `flush` still suppresses the allocation.
- `RENAME_FREE_BYPASS_EN` undefined: `alloc_ready` depends on state only, and an empty list stalls the front end for one cycle past the commit.

## Test plan
- Reset with NUM_REG = 32 -> `translation[i]` = i, `p_reg` = 16, `free_count` = 16, `alloc_ready` = 1.
- Allocation of arch 3, then arch 3 again on back-to-back cycles:
  - First cycle: `p_reg` = 16, `prev_preg` = 3.
  - Second cycle: `p_reg` = 17, `prev_preg` = 16.
  - Then `translation[3]` = 17 and `free_count` = 14.
- 16 allocations with no commits -> `alloc_ready` = 0 and a 17th `alloc_req` changes nothing. Then commit (arch 0, preg 16, prev 0):
  - Bypass undefined: `alloc_ready` = 1 next cycle and `p_reg` = 0.
  - Bypass defined: `alloc_ready` = 1 in the commit cycle with `p_reg` = 0.
- Allocate arch 1 -> 16, arch 2 -> 17; commit the first; then `flush` -> `translation[1]` = 16, `translation[2]` = 2, `free_count` = 16, `p_reg` = 17.
- Same-cycle `flush` + `commit_valid` + `alloc_req` -> commit applied, allocation dropped, `spec_map` equals the post-commit `comm_map`.
- Wrap-around: 1000 random allocate/commit sequences with NUM_REG = 64 (D = 48) -> pointers wrap correctly. A scoreboard confirms no physical register is ever mapped twice and that free count plus mapped count equals 64.

Source files
------------

// File: rtl/rename_table.sv
// rename_table: register-rename controller for the out-of-order front end.
// Keeps the speculative arch->phys map (driven onto `translation`), a
// committed map for flush rollback, and a circular free list that supplies
// the destination physical register for each renamed instruction.
// Optional feature macro: RENAME_FREE_BYPASS_EN lets an allocation take the
// register a same-cycle commit is freeing when the free list is empty.
// Default physical register count comes from the NUM_REG macro (32 if unset).

`ifndef NUM_REG
`define NUM_REG 32
`endif

module rename_table #(
    parameter int NUM_REG = `NUM_REG
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             alloc_req,
    input  logic [3:0]                       alloc_arch,
    output logic                             alloc_ready,
    output logic [$clog2(NUM_REG)-1:0]       p_reg,
    output logic [$clog2(NUM_REG)-1:0]       prev_preg,
    input  logic                             commit_valid,
    input  logic [3:0]                       commit_arch,
    input  logic [$clog2(NUM_REG)-1:0]       commit_preg,
    input  logic [$clog2(NUM_REG)-1:0]       commit_prev_preg,
    input  logic                             flush,
    output logic [$clog2(NUM_REG)-1:0]       translation [16],
    output logic [$clog2(NUM_REG-16+1)-1:0]  free_count
);

    localparam int P  = $clog2(NUM_REG);
    localparam int D  = NUM_REG - 16;      // free-list depth
    localparam int PW = $clog2(D);         // free-list pointer width
    localparam int CW = $clog2(D + 1);     // free counter width, holds 0..D

    // Map and free-list storage
    logic [P-1:0]  spec_map_q [16];
    logic [P-1:0]  spec_map_d [16];
    logic [P-1:0]  comm_map_q [16];
    logic [P-1:0]  comm_map_d [16];
    logic [P-1:0]  fl_q [D];
    logic [P-1:0]  fl_d [D];

    // head: next slot to allocate; comm_head: oldest uncommitted allocation;
    // tail: next slot a freed register is written to.
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] comm_head_q, comm_head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          alloc_fire;

    // Pointer increment that wraps at D-1; D need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    // Allocation handshake and granted register; state-only unless the bypass is built in.
    always_comb begin
        alloc_ready = (count_q != '0);
        p_reg       = fl_q[head_q];
`ifdef RENAME_FREE_BYPASS_EN
        // Empty list: hand the register being freed this cycle straight to the allocator.
        if ((count_q == '0) && commit_valid) begin
            alloc_ready = 1'b1;
            p_reg       = commit_prev_preg;
        end
`endif
    end

    assign alloc_fire = alloc_req & alloc_ready & ~flush;
    assign prev_preg  = spec_map_q[alloc_arch];
    assign free_count = count_q;

    // Decoder sees the speculative map as registered; updates show up the next cycle.
    always_comb begin
        translation = spec_map_q;
    end

    // Next-state: commit first, then either flush rollback or a speculative allocation.
    always_comb begin
        spec_map_d  = spec_map_q;
        comm_map_d  = comm_map_q;
        fl_d        = fl_q;
        head_d      = head_q;
        comm_head_d = comm_head_q;
        tail_d      = tail_q;
        count_d     = count_q;

        if (commit_valid) begin
            fl_d[tail_q]            = commit_prev_preg;
            tail_d                  = ptr_inc(tail_q);
            comm_head_d             = ptr_inc(comm_head_q);
            comm_map_d[commit_arch] = commit_preg;
        end

        if (flush) begin
            // Rollback sees the same-cycle commit; every uncommitted allocation is freed,
            // which leaves the list logically full again (tail tracks comm_head).
            spec_map_d = comm_map_d;
            head_d     = comm_head_d;
            count_d    = CW'(D);
        end else begin
            if (alloc_fire) begin
                spec_map_d[alloc_arch] = p_reg;
                head_d                 = ptr_inc(head_q);
            end
            // Alloc+commit together leaves the count unchanged (also covers the bypass case).
            case ({alloc_fire, commit_valid})
                2'b10:   count_d = count_q - CW'(1);
                2'b01:   count_d = count_q + CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous restore of the identity map and full free list.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 16; i++) begin
                spec_map_q[i] <= P'(i);
                comm_map_q[i] <= P'(i);
            end
            for (int k = 0; k < D; k++) begin
                fl_q[k] <= P'(16 + k);
            end
            head_q      <= '0;
            comm_head_q <= '0;
            tail_q      <= '0;
            count_q     <= CW'(D);
        end else begin
            spec_map_q  <= spec_map_d;
            comm_map_q  <= comm_map_d;
            fl_q        <= fl_d;
            head_q      <= head_d;
            comm_head_q <= comm_head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

`ifndef SYNTHESIS
    // A commit must retire an outstanding allocation, in allocation order.
    always @(posedge clk) begin
        if (n_rst && commit_valid) begin
            assert (count_q != CW'(D));
            assert (commit_preg == fl_q[comm_head_q]);
        end
    end
`endif

endmodule
